// File: rtl/wb_pkg.sv
// Shared types and default geometry for the wait buffer.
// The entry struct here matches the default parameter set of wait_buffer_v2.
package wb_pkg;

   localparam int unsigned WB_DATA_WIDTH     = 32;
   localparam int unsigned WB_ADDR_BITS      = 32;
   localparam int unsigned WB_BLOCK_ID_START = 5;
   localparam int unsigned WB_R_WIDTH        = 6;
   localparam int unsigned WB_ROB_TICKET     = 3;
   localparam int unsigned WB_DEPTH          = 8;

   localparam int unsigned BE_W  = WB_DATA_WIDTH / 8;
   localparam int unsigned CNT_W = $clog2(WB_DEPTH + 1);

   typedef struct packed {
      logic                     is_store;
      logic [WB_ADDR_BITS-1:0]  addr;
      logic [WB_DATA_WIDTH-1:0] data;
      logic [BE_W-1:0]          be;
      logic [WB_R_WIDTH-1:0]    dest;
      logic [WB_ROB_TICKET-1:0] ticket;
   } wb_entry_t;

   typedef enum logic {WB_IDLE, WB_WALK} wb_state_e;

endpackage

// File: rtl/wb_age_arbiter.sv
// Rotating-priority one-hot picker: first request found walking from start,
// upward (oldest-first) or downward (youngest-first) modulo DEPTH.
module wb_age_arbiter #(
   parameter int unsigned DEPTH          = 8,
   parameter bit          YOUNGEST_FIRST = 1'b0
) (
   input  logic [DEPTH-1:0]         req,
   input  logic [$clog2(DEPTH)-1:0] start,
   output logic [DEPTH-1:0]         gnt
);

   localparam int unsigned IDX_BITS = $clog2(DEPTH);

   always_comb begin
      logic [IDX_BITS-1:0] idx;
      logic                found;
      gnt   = '0;
      found = 1'b0;
      idx   = start;
      for (int k = 0; k < DEPTH; k++) begin
         idx = YOUNGEST_FIRST ? (start - IDX_BITS'(k)) : (start + IDX_BITS'(k));
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wait_buffer_v2.sv
// Age-ordered wait buffer for the non-blocking data cache: byte-accurate store
// forwarding to younger loads and per-block replay on refill.
module wait_buffer_v2
   import wb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = WB_DATA_WIDTH,
   parameter int unsigned ADDR_BITS      = WB_ADDR_BITS,
   parameter int unsigned BLOCK_ID_START = WB_BLOCK_ID_START,
   parameter int unsigned R_WIDTH        = WB_R_WIDTH,
   parameter int unsigned ROB_TICKET     = WB_ROB_TICKET,
   parameter int unsigned DEPTH          = WB_DEPTH
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                wr_valid,
   output logic                                wr_ready,
   input  logic                                wr_is_store,
   input  logic [ADDR_BITS-1:0]                wr_addr,
   input  logic [DATA_WIDTH-1:0]               wr_data,
   input  logic [DATA_WIDTH/8-1:0]             wr_be,
   input  logic [R_WIDTH-1:0]                  wr_dest,
   input  logic [ROB_TICKET-1:0]               wr_ticket,
   input  logic [ADDR_BITS-1:0]                fwd_addr,
   input  logic [DATA_WIDTH/8-1:0]             fwd_be,
   output logic                                fwd_hit,
   output logic                                fwd_conflict,
   output logic [DATA_WIDTH-1:0]               fwd_data,
   input  logic                                refill_valid,
   output logic                                refill_ready,
   input  logic [ADDR_BITS-BLOCK_ID_START-1:0] refill_block,
   output logic                                rp_valid,
   input  logic                                rp_ready,
   output logic                                rp_is_store,
   output logic [ADDR_BITS-1:0]                rp_addr,
   output logic [DATA_WIDTH-1:0]               rp_data,
   output logic [DATA_WIDTH/8-1:0]             rp_be,
   output logic [R_WIDTH-1:0]                  rp_dest,
   output logic [ROB_TICKET-1:0]               rp_ticket,
   input  logic                                flush,
   output logic [$clog2(DEPTH+1)-1:0]          count,
   output logic                                empty,
   output logic                                in_walk
);

   localparam int unsigned BE_BITS  = DATA_WIDTH / 8;
   localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);
   localparam int unsigned IDX_BITS = $clog2(DEPTH);

   typedef struct packed {
      logic                  is_store;
      logic [ADDR_BITS-1:0]  addr;
      logic [DATA_WIDTH-1:0] data;
      logic [BE_BITS-1:0]    be;
      logic [R_WIDTH-1:0]    dest;
      logic [ROB_TICKET-1:0] ticket;
   } entry_t;

   localparam int unsigned ENTRY_BITS = $bits(entry_t);

   entry_t              mem_q [DEPTH];
   logic [DEPTH-1:0]    valid_q, valid_d;
   logic [DEPTH-1:0]    snap_q, snap_d;
   logic [IDX_BITS-1:0] head_q, tail_q, youngest;
   logic [CNT_BITS-1:0] count_q;
   wb_state_e           state_q;

   logic                full, alloc, pop, refill_fire, rp_fire, fwd_any, fwd_cover;
   logic [DEPTH-1:0]    blk_match, fwd_match, rp_gnt, fwd_gnt;
   logic [ENTRY_BITS-1:0] rp_vec, fwd_vec;
   entry_t              rp_sel, fwd_sel;
   logic                unused_fwd_lsb;

   assign unused_fwd_lsb = ^fwd_addr[1:0];

   // Full/empty come from the span counter so head==tail is never ambiguous.
   assign full         = (count_q == CNT_BITS'(DEPTH));
   assign wr_ready     = ~full;
   assign alloc        = wr_valid & ~full;
   assign pop          = ~valid_q[head_q] & (count_q != '0);
   assign refill_ready = (state_q == WB_IDLE);
   assign in_walk      = (state_q == WB_WALK);
   assign rp_valid     = in_walk;
   assign refill_fire  = refill_valid & refill_ready;
   assign rp_fire      = rp_valid & rp_ready;
   assign count        = count_q;
   assign empty        = (count_q == '0);
   assign youngest     = tail_q - IDX_BITS'(1);

   always_comb begin
      blk_match = '0;
      fwd_match = '0;
      for (int i = 0; i < DEPTH; i++) begin
         blk_match[i] = (mem_q[i].addr[ADDR_BITS-1:BLOCK_ID_START] == refill_block);
         fwd_match[i] = valid_q[i] & mem_q[i].is_store &
                        (mem_q[i].addr[ADDR_BITS-1:2] == fwd_addr[ADDR_BITS-1:2]);
      end
   end

   wb_age_arbiter #(
      .DEPTH          (DEPTH),
      .YOUNGEST_FIRST (1'b0)
   ) u_rp_arb (
      .req   (snap_q),
      .start (head_q),
      .gnt   (rp_gnt)
   );

   wb_age_arbiter #(
      .DEPTH          (DEPTH),
      .YOUNGEST_FIRST (1'b1)
   ) u_fwd_arb (
      .req   (fwd_match),
      .start (youngest),
      .gnt   (fwd_gnt)
   );

   always_comb begin
      rp_vec  = '0;
      fwd_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         rp_vec  = rp_vec  | ({ENTRY_BITS{rp_gnt[i]}}  & mem_q[i]);
         fwd_vec = fwd_vec | ({ENTRY_BITS{fwd_gnt[i]}} & mem_q[i]);
      end
   end

   assign rp_sel  = entry_t'(rp_vec);
   assign fwd_sel = entry_t'(fwd_vec);

   assign rp_is_store = rp_sel.is_store;
   assign rp_addr     = rp_sel.addr;
   assign rp_data     = rp_sel.data;
   assign rp_be       = rp_sel.be;
   assign rp_dest     = rp_sel.dest;
   assign rp_ticket   = rp_sel.ticket;

   assign fwd_any      = |fwd_match;
   assign fwd_cover    = ((fwd_sel.be & fwd_be) == fwd_be);
   assign fwd_hit      = fwd_any & fwd_cover;
   assign fwd_conflict = fwd_any & ~fwd_cover;
   assign fwd_data     = fwd_sel.data;

   // Snapshot only sees entries valid before the refill cycle.
   always_comb begin
      valid_d = valid_q;
      snap_d  = snap_q;
      if (rp_fire) begin
         valid_d = valid_d & ~rp_gnt;
         snap_d  = snap_d & ~rp_gnt;
      end
      if (alloc) begin
         valid_d[tail_q] = 1'b1;
      end
      if (refill_fire) begin
         snap_d = valid_q & blk_match;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         valid_q <= '0;
         snap_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         snap_q  <= snap_d;
         if (alloc) tail_q <= tail_q + IDX_BITS'(1);
         if (pop)   head_q <= head_q + IDX_BITS'(1);
         case ({alloc, pop})
            2'b10:   count_q <= count_q + CNT_BITS'(1);
            2'b01:   count_q <= count_q - CNT_BITS'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         state_q <= WB_IDLE;
      end else begin
         case (state_q)
            WB_IDLE: if (|snap_d)  state_q <= WB_WALK;
            WB_WALK: if (~|snap_d) state_q <= WB_IDLE;
            default: state_q <= WB_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (alloc) begin
         mem_q[tail_q] <= '{is_store: wr_is_store, addr: wr_addr, data: wr_data, be: wr_be,
                            dest: wr_dest, ticket: wr_ticket};
      end
   end

endmodule

// File: tb/tb_wait_buffer_v2.sv
// Bench for wait_buffer_v2: forwarding vector table plus a replay scoreboard
// fed by an age-ordered model of live entries.
module tb_wait_buffer_v2;
   import wb_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_valid, wr_ready, wr_is_store;
   logic [31:0] wr_addr, wr_data;
   logic [3:0]  wr_be;
   logic [5:0]  wr_dest;
   logic [2:0]  wr_ticket;
   logic [31:0] fwd_addr;
   logic [3:0]  fwd_be;
   logic        fwd_hit, fwd_conflict;
   logic [31:0] fwd_data;
   logic        refill_valid, refill_ready;
   logic [26:0] refill_block;
   logic        rp_valid, rp_ready, rp_is_store;
   logic [31:0] rp_addr, rp_data;
   logic [3:0]  rp_be;
   logic [5:0]  rp_dest;
   logic [2:0]  rp_ticket;
   logic        flush;
   logic [3:0]  count;
   logic        empty, in_walk;

   always #5 clk = ~clk;

   wait_buffer_v2 dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_is_store  (wr_is_store),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_be        (wr_be),
      .wr_dest      (wr_dest),
      .wr_ticket    (wr_ticket),
      .fwd_addr     (fwd_addr),
      .fwd_be       (fwd_be),
      .fwd_hit      (fwd_hit),
      .fwd_conflict (fwd_conflict),
      .fwd_data     (fwd_data),
      .refill_valid (refill_valid),
      .refill_ready (refill_ready),
      .refill_block (refill_block),
      .rp_valid     (rp_valid),
      .rp_ready     (rp_ready),
      .rp_is_store  (rp_is_store),
      .rp_addr      (rp_addr),
      .rp_data      (rp_data),
      .rp_be        (rp_be),
      .rp_dest      (rp_dest),
      .rp_ticket    (rp_ticket),
      .flush        (flush),
      .count        (count),
      .empty        (empty),
      .in_walk      (in_walk)
   );

   int        n_checks = 0;
   int        n_fail   = 0;
   wb_entry_t model_q[$];   // live entries, oldest first
   wb_entry_t exp_q[$];     // replays still owed by the DUT
   wb_entry_t mon_got;

   typedef struct packed {
      logic        st;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] q_addr;
      logic [3:0]  q_be;
      logic        hit;
      logic        conf;
      logic [31:0] fdata;
   } fwd_vec_t;

   fwd_vec_t vecs [7];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic wb_entry_t mk(input logic st, input logic [31:0] addr,
                                    input logic [31:0] data, input logic [3:0] be,
                                    input logic [2:0] tk);
      wb_entry_t e;
      e = '{is_store: st, addr: addr, data: data, be: be, dest: {3'b101, tk}, ticket: tk};
      return e;
   endfunction

   task automatic drive_wr(input wb_entry_t e);
      wr_valid    = 1'b1;
      wr_is_store = e.is_store;
      wr_addr     = e.addr;
      wr_data     = e.data;
      wr_be       = e.be;
      wr_dest     = e.dest;
      wr_ticket   = e.ticket;
   endtask

   task automatic alloc(input wb_entry_t e, input bit accept);
      drive_wr(e);
      #1;
      check("wr_ready", wr_ready, accept);
      step();
      wr_valid = 1'b0;
      if (accept) model_q.push_back(e);
   endtask

   task automatic refill(input logic [31:0] addr);
      wb_entry_t keep[$];
      refill_valid = 1'b1;
      refill_block = addr[31:5];
      check("refill_ready", refill_ready, 1);
      keep = {};
      foreach (model_q[i]) begin
         if (model_q[i].addr[31:5] == addr[31:5]) exp_q.push_back(model_q[i]);
         else keep.push_back(model_q[i]);
      end
      model_q = keep;
      step();
      refill_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int cyc = 0;
      while ((in_walk || exp_q.size() != 0) && cyc < 50) begin
         step();
         cyc++;
      end
      check(name, {in_walk, exp_q.size() != 0}, 0);
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      wr_valid     = 1'b0;
      wr_is_store  = 1'b0;
      wr_addr      = '0;
      wr_data      = '0;
      wr_be        = '0;
      wr_dest      = '0;
      wr_ticket    = '0;
      fwd_addr     = '0;
      fwd_be       = '0;
      refill_valid = 1'b0;
      refill_block = '0;
      rp_ready     = 1'b0;
      flush        = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      exp_q.delete();
      model_q.delete();
   endtask

   // A handshake seen at the falling edge commits at the next rising edge.
   always @(negedge clk) begin
      if (rst_n && rp_valid && rp_ready && !flush) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rp_unexpected: got ticket %0d, expected no replay", rp_ticket);
         end else begin
            mon_got = '{is_store: rp_is_store, addr: rp_addr, data: rp_data, be: rp_be,
                        dest: rp_dest, ticket: rp_ticket};
            check("rp_entry", mon_got, exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b1, 32'h1000, 32'hAABBCCDD, 4'b0011, 32'h1000, 4'b0100, 1'b0, 1'b1, 32'hAABBCCDD};
      vecs[1] = '{1'b1, 32'h1000, 32'h11223344, 4'b1111, 32'h1000, 4'b0001, 1'b1, 1'b0, 32'h11223344};
      vecs[2] = '{1'b0, 32'h2000, 32'h00000000, 4'b1111, 32'h2000, 4'b1111, 1'b0, 1'b0, 32'h00000000};
      vecs[3] = '{1'b1, 32'h1004, 32'h55667788, 4'b1100, 32'h1004, 4'b1000, 1'b1, 1'b0, 32'h55667788};
      vecs[4] = '{1'b1, 32'h1000, 32'h000000EE, 4'b0001, 32'h1000, 4'b0011, 1'b0, 1'b1, 32'h000000EE};
      vecs[5] = '{1'b0, 32'h3000, 32'h00000000, 4'b1111, 32'h1004, 4'b0100, 1'b1, 1'b0, 32'h55667788};
      vecs[6] = '{1'b1, 32'h4000, 32'hDEADBEEF, 4'b1111, 32'h4003, 4'b1111, 1'b1, 1'b0, 32'hDEADBEEF};

      // Reset state and fill to capacity
      do_reset();
      check("rst_wr_ready", wr_ready, 1);
      check("rst_empty", empty, 1);
      check("rst_count", count, 0);
      check("rst_in_walk", in_walk, 0);
      check("rst_rp_valid", rp_valid, 0);
      check("rst_refill_ready", refill_ready, 1);
      check("rst_fwd", {fwd_hit, fwd_conflict, fwd_data}, 0);
      rp_ready = 1'b1;
      for (int i = 0; i < 8; i++) alloc(mk(1'b0, 32'h0001_0000 + 32'(i * 32), 0, 4'hF, 3'(i)), 1);
      check("full_count", count, 8);
      check("full_wr_ready", wr_ready, 0);
      check("full_empty", empty, 0);
      alloc(mk(1'b0, 32'h0009_0000, 32'h0, 4'hF, 3'd0), 0);
      check("full_ignored_count", count, 8);
      refill(32'h0009_0000);
      check("empty_snapshot_idle", in_walk, 0);
      refill(32'h0001_0000);
      check("walk_entered", in_walk, 1);
      wait_done("full_walk_done");
      step();
      step();
      check("after_pop_count", count, 7);
      check("after_pop_wr_ready", wr_ready, 1);

      // Forwarding table
      do_reset();
      for (int i = 0; i < 7; i++) begin
         alloc(mk(vecs[i].st, vecs[i].addr, vecs[i].data, vecs[i].be, 3'(i)), 1);
         fwd_addr = vecs[i].q_addr;
         fwd_be   = vecs[i].q_be;
         #1;
         check($sformatf("fwd_hit_%0d", i), fwd_hit, vecs[i].hit);
         check($sformatf("fwd_conflict_%0d", i), fwd_conflict, vecs[i].conf);
         check($sformatf("fwd_data_%0d", i), fwd_data, vecs[i].fdata);
      end

      // Replay of blocks A,B,A,A: slots 0,2,3 then slot 1 later
      do_reset();
      rp_ready = 1'b1;
      alloc(mk(1'b0, 32'h2000, 32'h0, 4'hF, 3'd0), 1);
      alloc(mk(1'b1, 32'h4000, 32'hCAFE0001, 4'h3, 3'd1), 1);
      alloc(mk(1'b1, 32'h2004, 32'hCAFE0002, 4'hC, 3'd2), 1);
      alloc(mk(1'b0, 32'h2008, 32'h0, 4'hF, 3'd3), 1);
      refill(32'h2000);
      check("a_walk_c1", in_walk, 1);
      step();
      check("a_walk_c2", in_walk, 1);
      step();
      check("a_walk_c3", in_walk, 1);
      step();
      check("a_walk_exit", in_walk, 0);
      check("a_replays_done", exp_q.size(), 0);
      step();
      step();
      check("a_head_stops_count", count, 3);
      refill(32'h4000);
      wait_done("b_walk_done");
      for (int i = 0; i < 4; i++) step();
      check("b_drained_empty", empty, 1);

      // Allocate into the walking block, replay stalled
      do_reset();
      alloc(mk(1'b0, 32'h2000, 32'h0, 4'hF, 3'd0), 1);
      alloc(mk(1'b1, 32'h2010, 32'h89ABCDEF, 4'hF, 3'd1), 1);
      refill(32'h2000);
      alloc(mk(1'b0, 32'h200C, 32'h0, 4'hF, 3'd2), 1);
      for (int i = 0; i < 3; i++) begin
         check("stall_rp_valid", rp_valid, 1);
         check("stall_rp_fields", {rp_ticket, rp_addr, rp_dest}, {3'd0, 32'h2000, 6'b101000});
         step();
      end
      rp_ready = 1'b1;
      wait_done("stall_walk_done");
      step();
      step();
      check("late_entry_count", count, 1);
      refill(32'h2000);
      wait_done("late_entry_walk_done");

      // Pointer wrap across slot 7 -> 0
      do_reset();
      rp_ready = 1'b1;
      for (int i = 0; i < 6; i++) alloc(mk(1'b0, 32'h6000 + 32'(i * 4), 0, 4'hF, 3'(i)), 1);
      refill(32'h6000);
      wait_done("wrap_first_walk");
      for (int i = 0; i < 8; i++) step();
      check("wrap_drained_count", count, 0);
      alloc(mk(1'b0, 32'h8000, 32'h0, 4'hF, 3'd6), 1);
      alloc(mk(1'b1, 32'hA000, 32'h11111111, 4'hF, 3'd7), 1);
      alloc(mk(1'b1, 32'hA000, 32'h22222222, 4'hF, 3'd0), 1);
      alloc(mk(1'b0, 32'h8004, 32'h0, 4'hF, 3'd1), 1);
      check("wrap_count", count, 4);
      fwd_addr = 32'hA000;
      fwd_be   = 4'hF;
      #1;
      check("wrap_fwd", {fwd_hit, fwd_conflict, fwd_data}, {2'b10, 32'h22222222});
      refill(32'h8000);
      wait_done("wrap_d_walk");
      refill(32'hA000);
      wait_done("wrap_s_walk");
      for (int i = 0; i < 6; i++) step();
      check("wrap_final_empty", {empty, count}, {1'b1, 4'd0});

      // Flush in the middle of a walk
      do_reset();
      for (int i = 0; i < 3; i++) alloc(mk(1'b0, 32'hC000 + 32'(i * 4), 0, 4'hF, 3'(i)), 1);
      refill(32'hC000);
      rp_ready = 1'b1;
      step();
      flush = 1'b1;
      drive_wr(mk(1'b0, 32'hE000, 32'h0, 4'hF, 3'd5));
      step();
      flush    = 1'b0;
      wr_valid = 1'b0;
      check("flush_empty", empty, 1);
      check("flush_in_walk", in_walk, 0);
      check("flush_rp_valid", rp_valid, 0);
      check("flush_refill_ready", refill_ready, 1);
      check("flush_count", count, 0);
      exp_q.delete();
      model_q.delete();
      refill(32'hE000);
      check("flush_dropped_write", in_walk, 0);
      refill(32'hC000);
      check("flush_cleared_valid", in_walk, 0);
      alloc(mk(1'b0, 32'hE000, 32'h0, 4'hF, 3'd3), 1);
      refill(32'hE000);
      wait_done("post_flush_walk");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
